cache_miss_ctrl: RTL

Miss-handling sequencer for the 2-way set-associative, 9-bit-address, 8-bit-data cache. It sits between the tag/data arrays and main memory. It detects a CPU miss and stalls the CPU. If the victim way is dirty, it writes the victim line back as a 4-beat burst. It then refills the line as a 4-beat burst and commits the new tag. Hits and CPU-side data muxing stay in the cache datapath; this block only sequences misses.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_beat_ctr.sv | 34 +++
 rtl/cache_miss_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared constants, FSM state type and address field helpers for the
// 2-way, 9-bit-address cache miss sequencer.
package cache_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int TAG_W  = 4;
    localparam int IDX_W  = 3;
    localparam int OFF_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        RF     = 2'd2,
        UPDATE = 2'd3
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
        return a[OFF_W-1:0];
    endfunction

endpackage

// File: rtl/cache_beat_ctr.sv
// 2-bit burst beat counter: beat = start + beats completed (mod 4),
// last is high while the fourth beat of the burst is presented.
module cache_beat_ctr
    import cache_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [OFF_W-1:0] start,
    input  logic             adv,
    output logic [OFF_W-1:0] beat,
    output logic             last
);

    logic [OFF_W-1:0] start_q;
    logic [OFF_W-1:0] cnt_q;

    // load wins over adv so the final beat of one burst can seed the next
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            start_q <= start;
            cnt_q   <= '0;
        end else if (adv) begin
            cnt_q <= cnt_q + 2'd1;
        end
    end

    assign beat = start_q + cnt_q;
    assign last = &cnt_q;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss sequencer: detect, optional dirty write-back burst, refill burst, tag commit.
// Optional build macro CACHE_CRITICAL_WORD_FIRST_EN starts the refill at the missed offset.
module cache_miss_ctrl
    import cache_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_cpu,
    input  logic              wr_cpu,
    input  logic [ADDR_W-1:0] addr_cpu,
    input  logic              hit,
    input  logic              victim_way,
    input  logic              victim_valid,
    input  logic              victim_dirty,
    input  logic [TAG_W-1:0]  victim_tag,
    input  logic [DATA_W-1:0] evict_data,
    output logic              stall_cpu,
    output logic [ADDR_W-1:0] addr_mem,
    output logic              rd_mem,
    output logic              wr_mem,
    input  logic              ready_mem,
    input  logic [DATA_W-1:0] data_mem_in,
    output logic [DATA_W-1:0] data_mem_out,
    output logic              array_way,
    output logic [IDX_W-1:0]  array_index,
    output logic [OFF_W-1:0]  array_offset,
    output logic              array_we,
    output logic              tag_we,
    output state_t            state_dbg
);

    // Memory handshake: a beat transfers on every cycle where rd_mem or wr_mem
    // is high and ready_mem is high; while ready_mem is low every beat output holds.

    state_t state_q, state_d;

    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] index_q;
    logic [TAG_W-1:0] victim_tag_q;
    logic             victim_way_q;

    logic             miss;
    logic             ctr_load;
    logic [OFF_W-1:0] ctr_start;
    logic             ctr_adv;
    logic [OFF_W-1:0] beat;
    logic             last;
    logic [OFF_W-1:0] idle_rf_start;
    logic [OFF_W-1:0] held_rf_start;
    logic [1:0]       unused_bits;

    assign miss = (rd_cpu | wr_cpu) & ~hit;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    logic [OFF_W-1:0] offset_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            offset_q <= '0;
        else if (state_q == IDLE && miss)
            offset_q <= addr_offset(addr_cpu);
    end

    assign idle_rf_start = addr_offset(addr_cpu);
    assign held_rf_start = offset_q;
    assign unused_bits   = {^data_mem_in, 1'b0};
`else
    assign idle_rf_start = '0;
    assign held_rf_start = '0;
    assign unused_bits   = {^data_mem_in, ^addr_cpu[OFF_W-1:0]};
`endif

    // Refill data flows straight from memory into the data array.

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_q        <= '0;
            index_q      <= '0;
            victim_tag_q <= '0;
            victim_way_q <= 1'b0;
        end else if (state_q == IDLE && miss) begin
            tag_q        <= addr_tag(addr_cpu);
            index_q      <= addr_index(addr_cpu);
            victim_tag_q <= victim_tag;
            victim_way_q <= victim_way;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        ctr_load     = 1'b0;
        ctr_start    = '0;
        ctr_adv      = 1'b0;
        addr_mem     = '0;
        rd_mem       = 1'b0;
        wr_mem       = 1'b0;
        data_mem_out = '0;
        array_way    = 1'b0;
        array_index  = '0;
        array_offset = '0;
        array_we     = 1'b0;
        tag_we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                ctr_load  = 1'b1;
                // a dirty victim writes back from beat 0; the refill start is reloaded afterwards
                ctr_start = (victim_valid & victim_dirty) ? '0 : idle_rf_start;
                if (miss)
                    state_d = (victim_valid & victim_dirty) ? WB : RF;
            end
            WB: begin
                wr_mem       = 1'b1;
                addr_mem     = {victim_tag_q, index_q, beat};
                data_mem_out = evict_data;
                array_way    = victim_way_q;
                array_index  = index_q;
                array_offset = beat;
                ctr_adv      = ready_mem;
                if (ready_mem && last) begin
                    ctr_load  = 1'b1;
                    ctr_start = held_rf_start;
                    state_d   = RF;
                end
            end
            RF: begin
                rd_mem       = 1'b1;
                addr_mem     = {tag_q, index_q, beat};
                array_way    = victim_way_q;
                array_index  = index_q;
                array_offset = beat;
                array_we     = ready_mem;
                ctr_adv      = ready_mem;
                if (ready_mem && last)
                    state_d = UPDATE;
            end
            UPDATE: begin
                tag_we      = 1'b1;
                array_way   = victim_way_q;
                array_index = index_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    cache_beat_ctr u_beat_ctr (
        .clock (clock),
        .reset (reset),
        .load  (ctr_load),
        .start (ctr_start),
        .adv   (ctr_adv),
        .beat  (beat),
        .last  (last)
    );

    assign stall_cpu = (state_q != IDLE) | miss;
    assign state_dbg = state_q;

endmodule
